// File: rtl/twisted_ring_counter.sv
// twisted_ring_counter
// Parametrised shift-register counter.
// - mode = 0: one-hot ring counter with period WIDTH.
// - mode = 1: Johnson (twisted-ring) counter with period 2*WIDTH.
// Features: count enable, up/down direction, parallel load, a decoded
// sequence index, a wrap pulse and an illegal-word error pulse.
// Optional feature macro: TRC_SELF_CORRECT_EN. When it is defined, illegal
// words are replaced by the start state and err pulses. When it is
// undefined, illegal words shift verbatim and err stays low.
module twisted_ring_counter #(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IW-1:0]    idx,
    output logic             wrap,
    output logic             err
);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Start state (sequence position 0) of the given mode.
    // Ring starts at 0...01; Johnson starts at all zeros.
    function automatic logic [WIDTH-1:0] start_state(input logic m);
        logic [WIDTH-1:0] s;
        s = {WIDTH{1'b0}};
        if (m == 1'b0) begin
            s[0] = 1'b1;
        end else begin
            s[0] = 1'b0;
        end
        return s;
    endfunction

    // Number of set bits in a word.
    function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
        int unsigned c;
        c = 32'd0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

    // Number of adjacent-bit transitions across v[WIDTH-1:0].
    function automatic int unsigned transitions(input logic [WIDTH-1:0] v);
        int unsigned c;
        c = 32'd0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            c = c + 32'(v[i] ^ v[i+1]);
        end
        return c;
    endfunction

    // A ring word is legal when exactly one bit is set.
    // A Johnson word is legal when it has at most one adjacent-bit transition.
    function automatic logic word_legal(input logic [WIDTH-1:0] v, input logic m);
        logic ok;
        if (m == 1'b0) begin
            ok = (popcount(v) == 32'd1);
        end else begin
            ok = (transitions(v) <= 32'd1);
        end
        return ok;
    endfunction

    // One step of the shift rule for the given mode and direction.
    // Up shifts toward the MSB; down shifts toward the LSB.
    // Johnson mode feeds back the inverted bit that leaves the register.
    function automatic logic [WIDTH-1:0] step_word(input logic [WIDTH-1:0] v,
                                                   input logic m,
                                                   input logic d);
        logic [WIDTH-1:0] n;
        case ({m, d})
            2'b00:   n = {v[WIDTH-2:0], v[WIDTH-1]};
            2'b01:   n = {v[0], v[WIDTH-1:1]};
            2'b10:   n = {v[WIDTH-2:0], ~v[WIDTH-1]};
            2'b11:   n = {~v[0], v[WIDTH-1:1]};
            default: n = v;
        endcase
        return n;
    endfunction

    // Decode the sequence position of a word; illegal words decode to 0.
    // For Johnson words, the filling half of the sequence (q[0] set, or
    // all zeros) is counted up by popcount. The draining half is counted
    // back from 2*WIDTH.
    function automatic logic [IW-1:0] decode_idx(input logic [WIDTH-1:0] v,
                                                 input logic m);
        logic [IW-1:0] r;
        int unsigned   pc;
        r  = {IW{1'b0}};
        pc = popcount(v);
        if (!word_legal(v, m)) begin
            r = {IW{1'b0}};
        end else if (m == 1'b0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) begin
                    r = IW'(i);
                end else begin
                    r = r;
                end
            end
        end else if (v[0] || (pc == 32'd0)) begin
            r = IW'(pc);
        end else begin
            r = IW'(32'(2 * WIDTH) - pc);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] q_q,    q_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic             err_q,  err_d;
    logic [WIDTH-1:0] stepped_s;

    assign stepped_s = step_word(q_q, mode_q, dir);

    // Next-state selection.
    // Priority: load > mode change > enabled step > hold.
    // Reset is applied in the register block.
    always_comb begin
        q_d    = q_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            mode_d = mode;
`ifdef TRC_SELF_CORRECT_EN
            if (word_legal(load_val, mode)) begin
                q_d = load_val;
            end else begin
                q_d   = start_state(mode);
                err_d = 1'b1;
            end
`else
            q_d = load_val;
`endif
        end else if (mode != mode_q) begin
            // A mode switch restarts the new sequence; it never counts as a wrap.
            q_d    = start_state(mode);
            mode_d = mode;
        end else if (en) begin
`ifdef TRC_SELF_CORRECT_EN
            if (word_legal(q_q, mode_q)) begin
                q_d    = stepped_s;
                wrap_d = (stepped_s == start_state(mode_q));
            end else begin
                q_d   = start_state(mode_q);
                err_d = 1'b1;
            end
`else
            // Illegal words never step onto the start state, so this
            // compare only fires for a genuine wrap.
            q_d    = stepped_s;
            wrap_d = (stepped_s == start_state(mode_q));
`endif
        end else begin
            q_d = q_q;
        end
    end

    // State register.
    // Synchronous reset returns to the start state of the mode sampled
    // on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= start_state(mode);
            mode_q <= mode;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;
    assign idx  = decode_idx(q_q, mode_q);

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Testbench for twisted_ring_counter (WIDTH = 4).
// The reference model tracks the sequence position arithmetically.
// - Ring word at position p: 1 << p.
// - Johnson word at position p: a run of p ones filling from the LSB,
//   then draining from the LSB.
// A word is legal when it appears in the sequence of its mode.
// Illegal words are kept as raw values and shifted by the bit rule.
module tb_twisted_ring_counter;

    localparam int W   = 4;
    localparam int IWB = $clog2(2 * W);

    logic           clk = 1'b0;
    logic           reset, en, mode, dir, load;
    logic [W-1:0]   load_val;
    logic [W-1:0]   q;
    logic [IWB-1:0] idx;
    logic           wrap, err;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic        m_mode;
    bit          m_legal;
    int          m_pos;
    int unsigned m_word;
    bit          m_wrap, m_err;

    twisted_ring_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .q(q), .idx(idx),
        .wrap(wrap), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int period(input logic md);
        return md ? 2 * W : W;
    endfunction

    function automatic int unsigned seq_word(input logic md, input int p);
        int unsigned mask;
        mask = (32'd1 << W) - 32'd1;
        if (!md) return 32'd1 << p;
        else if (p <= W) return (32'd1 << p) - 32'd1;
        else return mask & ~((32'd1 << (p - W)) - 32'd1);
    endfunction

    function automatic int find_pos(input logic md, input int unsigned w);
        for (int p = 0; p < period(md); p++) begin
            if (seq_word(md, p) == w) return p;
        end
        return -1;
    endfunction

    function automatic int unsigned shift_raw(input logic md, input logic d,
                                              input int unsigned w);
        int unsigned mask;
        mask = (32'd1 << W) - 32'd1;
        if (!md && !d) return ((w << 1) | (w >> (W - 1))) & mask;
        else if (!md)  return (w >> 1) | ((w & 32'd1) << (W - 1));
        else if (!d)   return ((w << 1) & mask) | (((w >> (W - 1)) & 32'd1) ^ 32'd1);
        else           return (w >> 1) | (((w & 32'd1) ^ 32'd1) << (W - 1));
    endfunction

    // Drive one cycle, advance the model, then check after the edge.
    task automatic step(input logic r, input logic e, input logic md,
                        input logic d, input logic ld,
                        input logic [W-1:0] lv, input string tag);
        int p;
        logic [W-1:0]   exp_q;
        logic [IWB-1:0] exp_idx;
        reset = r; en = e; mode = md; dir = d; load = ld; load_val = lv;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_mode = md; m_legal = 1'b1; m_pos = 0;
        end else if (ld) begin
            m_mode = md;
            p = find_pos(md, 32'(lv));
            if (p >= 0) begin
                m_legal = 1'b1; m_pos = p;
            end else begin
`ifdef TRC_SELF_CORRECT_EN
                m_legal = 1'b1; m_pos = 0; m_err = 1'b1;
`else
                m_legal = 1'b0; m_word = 32'(lv);
`endif
            end
        end else if (md != m_mode) begin
            m_mode = md; m_legal = 1'b1; m_pos = 0;
        end else if (e) begin
            if (m_legal) begin
                m_pos  = d ? (m_pos + period(m_mode) - 1) % period(m_mode)
                           : (m_pos + 1) % period(m_mode);
                m_wrap = (m_pos == 0);
            end else begin
`ifdef TRC_SELF_CORRECT_EN
                m_legal = 1'b1; m_pos = 0; m_err = 1'b1;
`else
                m_word = shift_raw(m_mode, d, m_word);
`endif
            end
        end
        exp_q   = m_legal ? W'(seq_word(m_mode, m_pos)) : W'(m_word);
        exp_idx = m_legal ? IWB'(m_pos) : IWB'(0);
        @(posedge clk);
        #1;
        checks++;
        assert (q === exp_q) else begin
            errors++; $error("FAIL %s q: got %b expected %b", tag, q, exp_q);
        end
        checks++;
        assert (idx === exp_idx) else begin
            errors++; $error("FAIL %s idx: got %0d expected %0d", tag, idx, exp_idx);
        end
        checks++;
        assert (wrap === m_wrap) else begin
            errors++; $error("FAIL %s wrap: got %b expected %b", tag, wrap, m_wrap);
        end
        checks++;
        assert (err === m_err) else begin
            errors++; $error("FAIL %s err: got %b expected %b", tag, err, m_err);
        end
    endtask

    logic [W-1:0] jt [8];
    logic         rr, ll, ee, dd, mm;
    logic [W-1:0] lv;

    initial begin
        jt = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
               4'b1110, 4'b1100, 4'b1000, 4'b0000};
        reset = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0;
        load_val = 4'b0000;
        m_mode = 1'b0; m_legal = 1'b1; m_pos = 0; m_word = 32'd0;
        m_wrap = 1'b0; m_err = 1'b0;
        @(negedge clk);

        // Reset in Johnson mode, then count up through the full period.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "rst_johnson");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "johnson_up");
            checks++;
            assert (q === jt[i]) else begin
                errors++; $error("FAIL johnson_table q: got %b expected %b", q, jt[i]);
            end
        end

        // Ring down from the start state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "rst_ring");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, "ring_down");

        // Load with a mode change, then hold.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111, "load");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, "hold");

        // Switch mode at run time without enable.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110, "load_1110");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, "mode_switch");

        // Load an illegal Johnson word, then step up.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, "illegal_load");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "illegal_step");

        // Reset in the middle of a count, then reverse direction every clock.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0111, "load_0111");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, "mid_reset");
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 1'b1, 1'(i % 2), 1'b0, 4'b0000, "reversal");

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rr = ($urandom_range(0, 39) == 0);
            ll = ($urandom_range(0, 7) == 0);
            mm = ($urandom_range(0, 9) == 0) ? ~mode : mode;
            ee = ($urandom_range(0, 3) != 0);
            dd = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                lv = W'(seq_word(mm, $urandom_range(0, period(mm) - 1)));
            else
                lv = W'($urandom);
            step(rr, ee, mm, dd, ll, lv, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
